// File: rtl/bft_up_arb_if.sv
// Valid/ready/last flit bundle for the BFT up-link arbiter; N lanes of W-bit flits packed lane 0 lowest.
// The source drives the master modport and the sink drives the slave modport.
interface bft_up_arb_if #(
  parameter int N = 1,
  parameter int W = 35
);
  logic [N*W-1:0] wdata;
  logic [N-1:0]   wvalid;
  logic [N-1:0]   wready;
  logic [N-1:0]   wlast;

  modport master (output wdata, output wvalid, output wlast, input  wready);
  modport slave  (input  wdata, input  wvalid, input  wlast, output wready);
endinterface

// File: rtl/bft_up_arb.sv
// Packet-aware round-robin arbiter sharing one registered upward BFT link among N_IN streams.
// Optional stall watchdog is built when BFT_UP_ARB_WATCHDOG_EN is defined.
module bft_up_arb #(
  parameter int N_IN     = 2,
  parameter int D_W      = 32,
  parameter int A_W      = 2,
  parameter int WD_LIMIT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  bft_up_arb_if.slave     s_axis,
  bft_up_arb_if.master    m_axis,
  output logic [N_IN-1:0] grant,
  output logic            busy,
  output logic            stall_err
);
  localparam int F_W   = A_W + D_W + 1;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_IN) s = s - N_IN;
    return s[IDX_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [F_W-1:0]     m_data_q;
  logic               m_vld_q, m_last_q;

  logic [IDX_W-1:0]   sel_idx, own_idx;
  logic               sel_vld, own_vld;
  logic               slot_free, accept, own_last;
  logic [F_W-1:0]     own_flit;

  // Round-robin search starting at rr_ptr
  always_comb begin
    sel_idx = rr_ptr_q;
    sel_vld = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (!sel_vld && s_axis.wvalid[wrap_add(rr_ptr_q, k)]) begin
        sel_idx = wrap_add(rr_ptr_q, k);
        sel_vld = 1'b1;
      end
    end
  end

  // FSM outputs: a lock overrides the search; nothing is granted while reset is held
  always_comb begin
    own_idx = sel_idx;
    own_vld = sel_vld;
    busy    = 1'b0;
    if (state_q == LOCKED) begin
      own_idx = lock_idx_q;
      own_vld = 1'b1;
      busy    = 1'b1;
    end
    if (rst) own_vld = 1'b0;
    grant = '0;
    if (own_vld) grant[own_idx] = 1'b1;
  end

  assign slot_free      = ~m_vld_q | m_axis.wready[0];
  assign own_flit       = s_axis.wdata[int'(own_idx)*F_W +: F_W];
  assign own_last       = s_axis.wlast[own_idx];
  assign accept         = ce & slot_free & own_vld & s_axis.wvalid[own_idx];
  assign s_axis.wready  = {N_IN{ce & slot_free}} & grant;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      if (own_last) begin
        state_d  = IDLE;
        rr_ptr_d = wrap_add(own_idx, 1);
      end else begin
        state_d    = LOCKED;
        lock_idx_d = own_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Output register stage; ce low freezes it even if downstream is ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else if (ce) begin
      if (accept) begin
        m_vld_q  <= 1'b1;
        m_data_q <= own_flit;
        m_last_q <= own_last;
      end else if (m_axis.wready[0]) begin
        m_vld_q  <= 1'b0;
      end
    end
  end

  assign m_axis.wdata  = m_data_q;
  assign m_axis.wvalid = m_vld_q;
  assign m_axis.wlast  = m_last_q;

`ifdef BFT_UP_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT - 1);

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] c);
    if (c >= WD_MAX) return c;
    return c + 1'b1;
  endfunction

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            stall_err_q;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (accept || state_q == IDLE) wd_cnt_d = '0;
    else if (ce)                   wd_cnt_d = wd_sat_inc(wd_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q    <= '0;
      stall_err_q <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      stall_err_q <= stall_err_q | (wd_cnt_q == WD_MAX);
    end
  end

  assign stall_err = stall_err_q;
`else
  // No watchdog built; the flag is constant low for any legal WD_LIMIT
  assign stall_err = (WD_LIMIT < 1);
`endif
endmodule
